// File: rtl/scancode_pkg.sv
// Shared scan-code constants, mode encodings and decoder FSM state encodings.
// Pure declarations: no logic, no latency, no flow control.
package scancode_pkg;

    localparam logic [7:0] SC_BREAK   = 8'hF0;
    localparam logic [7:0] SC_EXT     = 8'hE0;

    localparam logic [7:0] KEY_M2_DEF = 8'h1C;
    localparam logic [7:0] KEY_M1_DEF = 8'h3A;
    localparam logic [7:0] KEY_M0_DEF = 8'h32;

    localparam logic [1:0] MODE_0     = 2'b00;
    localparam logic [1:0] MODE_1     = 2'b01;
    localparam logic [1:0] MODE_2     = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_BRK     = 2'd1;
    localparam logic [1:0] ST_EXT     = 2'd2;
    localparam logic [1:0] ST_EXT_BRK = 2'd3;

endpackage

// File: rtl/prefix_timer.sv
// Loadable down-counter guarding stale scan-code prefixes; expired is combinational from the count.
// Load wins over decrement; the count holds at zero; there is no backpressure.
module prefix_timer #(
    parameter int TO_CYC = 50000,
    parameter int TO_W   = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic load,
    input  logic run,
    output logic expired
);

    localparam logic [TO_W-1:0] RELOAD = TO_W'(TO_CYC - 1);

    logic [TO_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = RELOAD;
        end else if (run && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = run && (cnt_q == '0);

endmodule

// File: rtl/scancode_mode_decoder.sv
// PS/2 scan-code to latched filter mode decoder; outputs registered, valid 1 clock after Listo rises.
// No backpressure: one byte consumed per Listo rising edge. SCAN_EXT_PREFIX_EN enables E0 prefix states.
module scancode_mode_decoder
    import scancode_pkg::*;
#(
    parameter int                DATA_W = 8,
    parameter int                MODE_W = 2,
    parameter logic [DATA_W-1:0] KEY_M2 = DATA_W'(KEY_M2_DEF),
    parameter logic [DATA_W-1:0] KEY_M1 = DATA_W'(KEY_M1_DEF),
    parameter logic [DATA_W-1:0] KEY_M0 = DATA_W'(KEY_M0_DEF),
    parameter int                TO_CYC = 50000,
    parameter int                TO_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] dato_in,
    input  logic              Listo,
    output logic [MODE_W-1:0] enable,
    output logic              mode_chg,
    output logic              bad_key
);

    logic [1:0]        state_q, state_d;
    logic [MODE_W-1:0] enable_q, enable_d;
    logic              mode_chg_q, mode_chg_d;
    logic              bad_key_q, bad_key_d;
    logic              listo_q;
    logic              byte_stb;
    logic              to_load, to_run, to_expired;
    logic              key_hit;
    logic [MODE_W-1:0] key_mode;

    assign byte_stb = Listo && !listo_q;
    assign to_run   = (state_q != ST_IDLE);

    always_comb begin
        key_hit  = 1'b1;
        key_mode = MODE_W'(MODE_0);
        if (dato_in == KEY_M2) begin
            key_mode = MODE_W'(MODE_2);
        end else if (dato_in == KEY_M1) begin
            key_mode = MODE_W'(MODE_1);
        end else if (dato_in == KEY_M0) begin
            key_mode = MODE_W'(MODE_0);
        end else begin
            key_hit = 1'b0;
        end
    end

    // A consumed byte always outranks a simultaneous timeout.
    always_comb begin
        state_d    = state_q;
        enable_d   = enable_q;
        mode_chg_d = 1'b0;
        bad_key_d  = 1'b0;
        to_load    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (byte_stb) begin
                    if (dato_in == DATA_W'(SC_BREAK)) begin
                        state_d = ST_BRK;
                        to_load = 1'b1;
`ifdef SCAN_EXT_PREFIX_EN
                    end else if (dato_in == DATA_W'(SC_EXT)) begin
                        state_d = ST_EXT;
                        to_load = 1'b1;
`endif
                    end else if (key_hit) begin
                        enable_d   = key_mode;
                        mode_chg_d = (key_mode != enable_q);
                    end else begin
                        bad_key_d = 1'b1;
                    end
                end
            end
`ifdef SCAN_EXT_PREFIX_EN
            ST_EXT: begin
                if (byte_stb) begin
                    if (dato_in == DATA_W'(SC_BREAK)) begin
                        state_d = ST_EXT_BRK;
                        to_load = 1'b1;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else if (to_expired) begin
                    state_d   = ST_IDLE;
                    bad_key_d = 1'b1;
                end
            end
`endif
            default: begin
                if (byte_stb) begin
                    state_d = ST_IDLE;
                end else if (to_expired) begin
                    state_d   = ST_IDLE;
                    bad_key_d = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            enable_q   <= MODE_W'(MODE_0);
            mode_chg_q <= 1'b0;
            bad_key_q  <= 1'b0;
            listo_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            enable_q   <= enable_d;
            mode_chg_q <= mode_chg_d;
            bad_key_q  <= bad_key_d;
            listo_q    <= Listo;
        end
    end

    prefix_timer #(
        .TO_CYC (TO_CYC),
        .TO_W   (TO_W)
    ) u_prefix_timer (
        .clk     (clk),
        .rst     (rst),
        .load    (to_load),
        .run     (to_run),
        .expired (to_expired)
    );

    assign enable   = enable_q;
    assign mode_chg = mode_chg_q;
    assign bad_key  = bad_key_q;

endmodule

// File: tb/tb_scancode_mode_decoder.sv
// Directed bench for scancode_mode_decoder with a short prefix timeout.
module tb_scancode_mode_decoder;

    localparam int TO_CYC = 8;
    localparam int TO_W   = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] dato_in = 8'h00;
    logic       Listo = 1'b0;
    logic [1:0] enable;
    logic       mode_chg;
    logic       bad_key;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    scancode_mode_decoder #(
        .TO_CYC (TO_CYC),
        .TO_W   (TO_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .dato_in  (dato_in),
        .Listo    (Listo),
        .enable   (enable),
        .mode_chg (mode_chg),
        .bad_key  (bad_key)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic outs(input string tag, input logic [1:0] e_en,
                        input logic e_chg, input logic e_bad);
        check({tag, ".enable"},   {6'd0, enable},   {6'd0, e_en});
        check({tag, ".mode_chg"}, {7'd0, mode_chg}, {7'd0, e_chg});
        check({tag, ".bad_key"},  {7'd0, bad_key},  {7'd0, e_bad});
    endtask

    // Raise Listo with a byte and return just after the consuming edge.
    task automatic put(input logic [7:0] b);
        @(negedge clk);
        dato_in = b;
        Listo   = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic drop();
        @(negedge clk);
        Listo = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        repeat (2) tick();
        outs("reset", 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;

        put(8'h1C);
        outs("make_1c", 2'b10, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) begin
            tick();
            outs("hold_1c", 2'b10, 1'b0, 1'b0);
        end
        drop();

        put(8'hF0);
        outs("brk_f0", 2'b10, 1'b0, 1'b0);
        drop();
        put(8'h1C);
        outs("brk_1c", 2'b10, 1'b0, 1'b0);
        drop();
        put(8'h3A);
        outs("make_3a", 2'b01, 1'b1, 1'b0);
        drop();

        put(8'h5A);
        outs("unmapped_5a", 2'b01, 1'b0, 1'b1);
        drop();
        tick();
        outs("unmapped_after", 2'b01, 1'b0, 1'b0);
        put(8'h3A);
        outs("repeat_3a", 2'b01, 1'b0, 1'b0);
        drop();

        put(8'hF0);
        drop();
        for (int k = 1; k < TO_CYC; k++) begin
            tick();
            check("timeout_early.bad_key", {7'd0, bad_key}, 8'd0);
        end
        tick();
        outs("timeout_fire", 2'b01, 1'b0, 1'b1);
        tick();
        outs("timeout_after", 2'b01, 1'b0, 1'b0);
        put(8'h32);
        outs("make_32", 2'b00, 1'b1, 1'b0);
        drop();

        put(8'hE0);
`ifdef SCAN_EXT_PREFIX_EN
        outs("ext_e0", 2'b00, 1'b0, 1'b0);
`else
        outs("ext_e0", 2'b00, 1'b0, 1'b1);
`endif
        drop();
        put(8'h1C);
`ifdef SCAN_EXT_PREFIX_EN
        outs("ext_1c", 2'b00, 1'b0, 1'b0);
`else
        outs("ext_1c", 2'b10, 1'b1, 1'b0);
`endif
        drop();
        put(8'h3A);
        outs("idle_3a", 2'b01, 1'b1, 1'b0);
        drop();

`ifdef SCAN_EXT_PREFIX_EN
        put(8'hE0);
        drop();
`endif
        put(8'hF0);
        drop();
        #2;
        rst = 1'b1;
        #1;
        outs("async_rst", 2'b00, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        put(8'h1C);
        outs("post_rst_1c", 2'b10, 1'b1, 1'b0);
        drop();

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
